// File: rtl/clk_div_glitchfree.sv
// clk_div_glitchfree
//   Programmable integer clock divider. It sits directly upstream of the
//   clock inverter/buffer cells and drives the divided-clock tree.
//   CLKOUT comes straight from a flop, so it cannot glitch. Ratio changes
//   and enable/disable only take effect at period boundaries, so the
//   divider never emits a runt pulse. The one exception is reset, which
//   may truncate a pulse.
//
// Handshake: LOAD is a single-cycle strobe with no ready. DIV is captured
//   on every CLK edge where LOAD=1. BUSY reports that a captured ratio is
//   waiting for the next period boundary.
//
// Ports:
//   CLK      in   source clock; all flops use its rising edge
//   RST      in   asynchronous, active-high reset
//   EN       in   run request, sampled on CLK
//   DIV      in   requested divide ratio (0 and 1 are clamped to 2)
//   LOAD     in   single-cycle strobe that captures DIV
//   CLKOUT   out  divided clock, registered
//   RUNNING  out  high in RUN and STOPPING
//   BUSY     out  a loaded ratio is pending and not yet applied
module clk_div_glitchfree #(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             LOAD,
    output logic             CLKOUT,
    output logic             RUNNING,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV     = DIV_W'(2);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clkout_q, clkout_d;

    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] high_len;
    logic             boundary;

    assign div_clamped = (DIV < MIN_DIV) ? MIN_DIV : DIV;

    // The last low cycle of a period. Ratio and stop decisions are only made here.
    assign boundary = (state_q != S_IDLE) && (cnt_q == div_act_q - DIV_W'(1));

    // State register, with the rest of the datapath flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_act_q <= RESET_DIV_V;
            pend_q    <= '0;
            busy_q    <= 1'b0;
            clkout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            clkout_q  <= clkout_d;
        end
    end

    // Next-state logic.
    // RUN->STOPPING on EN=0. STOPPING returns to RUN on EN=1. Otherwise
    // STOPPING finishes the current period and then goes to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (EN) state_d = S_RUN;
            S_RUN:      if (!EN) state_d = S_STOPPING;
            S_STOPPING: begin
                if (EN)            state_d = S_RUN;
                else if (boundary) state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Counter and ratio bookkeeping.
    // When LOAD coincides with a boundary, the freshly presented DIV is
    // applied and takes priority over any older pending value.
    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        if (state_q == S_IDLE) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            if (LOAD) div_act_d = div_clamped;
        end else if (boundary) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            if (LOAD)        div_act_d = div_clamped;
            else if (busy_q) div_act_d = pend_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (LOAD) begin
                pend_d = div_clamped;
                busy_d = 1'b1;
            end
        end
    end

    // Output logic.
    // CLKOUT is computed from the next-state count and ratio, so the
    // registered output lines up with the count on the same cycle.
    // The high phase lasts ceil(N/2) cycles.
    assign high_len = (div_act_d >> 1) + {{(DIV_W-1){1'b0}}, div_act_d[0]};

    always_comb begin
        clkout_d = 1'b0;
        if (state_d != S_IDLE) clkout_d = (cnt_d < high_len);
    end

    assign CLKOUT  = clkout_q;
    assign RUNNING = (state_q != S_IDLE);
    assign BUSY    = busy_q;

endmodule

// File: doc/clk_div_glitchfree.md
Name: clk_div_glitchfree

Overview:
- Programmable integer clock divider; sits directly upstream of the clock inverter/buffer cells and drives the divided-clock tree through them.
- CLKOUT is a flop output only, so it never glitches.
- Ratio changes and enable/disable take effect only at period boundaries. No runt pulses are ever emitted.

Parameters:
- DIV_W, 8, width of divide-ratio input and internal counter.
- RESET_DIV, 4, active divide ratio after reset; must be >= 2.

Ports:
- CLK  input  1  source clock; all flops on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  run request; sampled on CLK.
- DIV  input  DIV_W  requested divide ratio N; captured on LOAD.
- LOAD  input  1  single-cycle strobe that captures DIV.
- CLKOUT  output  1  divided clock, registered.
- RUNNING  output  1  high in RUN and STOPPING states.
- BUSY  output  1  a loaded ratio is pending, not yet applied.

Behaviour:
- Reset is asynchronous, active-high; one clock, CLK.
- Asserting RST immediately forces:
  - CLKOUT=0, RUNNING=0, BUSY=0;
  - state=IDLE, cnt=0;
  - div_act=RESET_DIV, pend cleared.
- Reset mid-period truncates the pulse; this is the only allowed truncation.
- Ratio clamp: any captured DIV value of 0 or 1 is stored as 2. Maximum ratio is 2^DIV_W-1.
- Waveform for active ratio N:
  - cnt runs 0..N-1 and wraps to 0.
  - CLKOUT=1 while cnt < ceil(N/2), else 0.
  - Even N gives 50% duty; odd N gives a high phase one cycle longer than the low phase.
  - CLKOUT is registered from the next-state cnt, so it changes only on CLK rising edges.
- Period boundary: the cycle in which cnt==N-1, i.e. the last low cycle.
- States:
  - IDLE: CLKOUT=0, cnt held 0. When EN=1 is sampled, go to RUN; CLKOUT=1 from the next edge, so latency is 1 cycle and cnt=0 on that cycle.
  - RUN: normal counting. When EN=0 is sampled, go to STOPPING; counting continues.
  - STOPPING: counting continues.
    - At the boundary with EN=0, go to IDLE with CLKOUT held 0.
    - If EN=1 is sampled before the boundary, return to RUN with no waveform disturbance.
- Ratio update:
  - In IDLE, LOAD writes div_act directly on the next edge. BUSY stays 0.
  - In RUN or STOPPING, LOAD writes pend and sets BUSY on the next edge.
  - At a boundary with BUSY=1: div_act<=pend, BUSY<=0, and the new N governs from the next cnt=0.
  - LOAD while BUSY=1 overwrites pend; the last value wins.
  - LOAD coinciding with a boundary: the newly presented DIV (clamped) is applied at that same boundary, and BUSY remains 0.
  - A pending ratio at the STOPPING->IDLE transition is applied on entry to IDLE, and BUSY clears.
- EN and LOAD together in IDLE: the new ratio governs the first period.
- Counter width is DIV_W; no overflow is possible because cnt < N <= 2^DIV_W-1.

Test Plan:
- Default ratio: RST pulse, then EN=1 held (div_act=4). Required CLKOUT: 0, then 1,1,0,0 repeating starting 1 cycle after EN is sampled; RUNNING=1.
- Odd ratio: in IDLE, LOAD with DIV=5, then EN=1. Required CLKOUT: 1,1,1,0,0 repeating; BUSY stays 0.
- Mid-period change: running with N=4, at cnt=1 pulse LOAD with DIV=3. Required:
  - BUSY=1 for cycles cnt=2..3;
  - current period completes as 1,1,0,0;
  - next periods are 1,1,0; BUSY=0 after the boundary.
- Stop without runt: N=6, drop EN at cnt=1. Required:
  - CLKOUT completes 1,1,1,0,0,0, then stays 0;
  - RUNNING falls after the boundary.
  - Separately, re-raising EN at cnt=4 of STOPPING must give an uninterrupted waveform.
- Clamp and overwrite: LOAD DIV=0 gives divide-by-2 (1,0). While BUSY, LOAD 7 then LOAD 9 at the next cycle. Required: only 9 is applied, giving 5 high and 4 low.
- Async reset: assert RST asynchronously mid-high phase. Required: CLKOUT, RUNNING and BUSY go 0 with no CLK edge; after release with EN=1, N=RESET_DIV.
